int_div_iterative: RTL and testbench
====================================

Name: int_div_iterative

Overview:
- Multi-cycle iterative integer divider; the inverse-direction companion to the team's combinational adders, subtractors and shifters.
- Restoring algorithm, one quotient bit per cycle.
- Returns quotient and remainder over a latency-insensitive val/rdy request/response interface.
- Sits beside the multiplier in execute-stage and accelerator datapaths wherever a single-cycle divider is too large.

Parameters:
- p_nbits, 32, operand/result width in bits; must be >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_val  input  1  request valid.
- req_rdy  output  1  divider ready to accept a request.
- req_a  input  p_nbits  dividend.
- req_b  input  p_nbits  divisor.
- req_signed  input  1  1 = two's-complement division; honoured only with INT_DIV_SIGNED_EN.
- resp_val  output  1  result valid.
- resp_rdy  input  1  consumer ready.
- resp_quot  output  p_nbits  quotient.
- resp_rem  output  p_nbits  remainder.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: state IDLE; resp_val=0; resp_quot=0; resp_rem=0; iteration counter=0.
- req_rdy = (state==IDLE) & !reset. It is combinational from state only and never depends on req_val.
- FSM states:
  - IDLE: req_rdy=1. On req_val&req_rdy, latch operands and go to CALC. Latched values: rem_reg=0, quot_reg=|a| (or a when unsigned), div_reg=|b|, sign flags, counter=p_nbits-1.
  - CALC: each cycle shift {rem_reg,quot_reg} left by 1 and compute trial = rem_reg_shifted - div_reg (p_nbits+1 bits).
    - If trial is non-negative: rem_reg=trial, quot LSB=1.
    - Otherwise: rem_reg=shifted, quot LSB=0.
    - When counter==0, apply sign correction, register the results and go to DONE; otherwise decrement the counter.
    - Inputs are ignored in CALC.
  - DONE: resp_val=1 and outputs are held stable. On resp_rdy, go to IDLE. A new request cannot be accepted in that same cycle.
- Latency:
  - CALC occupies exactly p_nbits cycles.
  - resp_val rises on the p_nbits-th rising edge after the acceptance edge.
  - Back-to-back throughput is one result per p_nbits+2 cycles with resp_rdy held high.
- Sign rules (signed mode):
  - Quotient is negated when sign(a)^sign(b).
  - Remainder takes the sign of a.
  - Invariant a == q*b + r holds modulo 2^p_nbits.
- Divide by zero (b==0):
  - quot = all ones, rem = a, in both modes.
  - The restoring loop produces this naturally for unsigned operands.
  - In signed mode, sign correction of the quotient is suppressed when b==0.
- Signed overflow: a = most-negative, b = -1 gives quot = a, rem = 0. This falls out of the two's-complement wrap; no special case is needed beyond width discipline.
- Width: the trial subtract is p_nbits+1 bits wide to capture the borrow; magnitudes are computed with wrap, so |most-negative| = most-negative, interpreted unsigned.
- Reset mid-operation (CALC or DONE): immediately return to IDLE and clear resp_val and outputs; the in-flight result is discarded.
- Simultaneous resp_rdy in DONE while req_val is high: only the response handshake completes; the request is accepted in the following cycle.

Optional Feature:
- Macro INT_DIV_SIGNED_EN.
- Defined: req_signed is latched at acceptance and the sign rules above apply.
- Undefined: req_signed is ignored and all division is unsigned. Sign/abs/negate logic is compiled out; the port remains for interface stability.

Decomposition:
- Package int_div_pkg:
  - state enum {IDLE, CALC, DONE}.
  - localparam for the counter width, $clog2(p_nbits).
- Sub-module int_div_step: combinational single restoring step.
  - Inputs: rem, quot, divisor.
  - Outputs: next rem, next quot.
  - Instantiated once in CALC.

Test Plan:
- Unsigned 32-bit: 100/7 -> quot=14, rem=2; resp_val exactly 32 edges after acceptance.
- Divide by zero: 0x1234/0 -> quot=0xFFFFFFFF, rem=0x1234. In signed mode, -5/0 -> quot=0xFFFFFFFF, rem=0xFFFFFFFB.
- Signed (macro on):
  - -7/2 -> quot=-3, rem=-1.
  - 7/-2 -> quot=-3, rem=1.
  - 0x80000000/-1 -> quot=0x80000000, rem=0.
- Backpressure: hold resp_rdy=0 for 10 cycles in DONE -> outputs stable, req_rdy=0 throughout; assert resp_rdy -> IDLE next cycle.
- Reset asserted mid-CALC (cycle 5) -> resp_val=0 immediately; after release, req_rdy=1 and a fresh 9/3 returns quot=3, rem=0.
- Random 1000 unsigned and signed pairs (p_nbits=8 and 32) against a reference model.

Source files
------------

// File: rtl/int_div_pkg.sv
// -----------------------------------------------------------------------------
// int_div_pkg
// Shared types and helpers for the iterative restoring divider.
//   state_e    : controller states IDLE / CALC / DONE
//   cnt_width(): iteration counter width for a given operand width
// -----------------------------------------------------------------------------
package int_div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int c_default_nbits = 32;

   // The counter must hold p_nbits-1; $clog2 gives that width for p_nbits >= 2.
   function automatic int cnt_width(input int nbits);
      return (nbits < 2) ? 1 : $clog2(nbits);
   endfunction

   localparam int c_default_cnt_w = cnt_width(c_default_nbits);

endpackage

// File: rtl/int_div_step.sv
// -----------------------------------------------------------------------------
// int_div_step
// One combinational restoring-division step.
//   rem, quot  : current partial remainder and dividend/quotient shift register
//   divisor    : divisor magnitude
//   rem_next   : remainder after shift and conditional subtract
//   quot_next  : shift register with the new quotient bit in its LSB
// -----------------------------------------------------------------------------
module int_div_step
   import int_div_pkg::*;
#(
   parameter int p_nbits = c_default_nbits
) (
   input  logic [p_nbits-1:0] rem,
   input  logic [p_nbits-1:0] quot,
   input  logic [p_nbits-1:0] divisor,
   output logic [p_nbits-1:0] rem_next,
   output logic [p_nbits-1:0] quot_next
);

   // One extra bit so the borrow of the trial subtract is visible as the sign.
   logic [p_nbits:0] shifted;
   logic [p_nbits:0] trial;

   assign shifted   = {rem, quot[p_nbits-1]};
   assign trial     = shifted - {1'b0, divisor};
   assign rem_next  = trial[p_nbits] ? shifted[p_nbits-1:0] : trial[p_nbits-1:0];
   assign quot_next = {quot[p_nbits-2:0], ~trial[p_nbits]};

endmodule

// File: rtl/int_div_iterative.sv
// -----------------------------------------------------------------------------
// int_div_iterative
// Multi-cycle restoring integer divider, one quotient bit per cycle, with
// val/rdy request and response handshakes.
//   clk, reset            : clock, asynchronous active-high reset
//   req_val/req_rdy       : request handshake; req_a dividend, req_b divisor
//   req_signed            : two's-complement request (INT_DIV_SIGNED_EN only)
//   resp_val/resp_rdy     : response handshake; resp_quot, resp_rem results
// Build option: define INT_DIV_SIGNED_EN to enable signed division; without it
// req_signed is ignored and every division is unsigned.
// Divide by zero returns quot = all ones, rem = dividend.
// -----------------------------------------------------------------------------
module int_div_iterative
   import int_div_pkg::*;
#(
   parameter int p_nbits = c_default_nbits
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               req_val,
   output logic               req_rdy,
   input  logic [p_nbits-1:0] req_a,
   input  logic [p_nbits-1:0] req_b,
   input  logic               req_signed,
   output logic               resp_val,
   input  logic               resp_rdy,
   output logic [p_nbits-1:0] resp_quot,
   output logic [p_nbits-1:0] resp_rem
);

   localparam int                 c_cnt_w    = cnt_width(p_nbits);
   localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(p_nbits - 1);

   state_e             state;
   state_e             state_next;
   logic [p_nbits-1:0] rem_reg;
   logic [p_nbits-1:0] quot_reg;
   logic [p_nbits-1:0] div_reg;
   logic [c_cnt_w-1:0] cnt_reg;
   logic [p_nbits-1:0] rem_step;
   logic [p_nbits-1:0] quot_step;
   logic [p_nbits-1:0] a_mag;
   logic [p_nbits-1:0] b_mag;
   logic [p_nbits-1:0] quot_fix;
   logic [p_nbits-1:0] rem_fix;
   logic               req_go;
   logic               calc_last;

   assign req_go    = req_val & req_rdy;
   assign calc_last = (cnt_reg == '0);

`ifdef INT_DIV_SIGNED_EN
   logic a_neg;
   logic b_neg;
   logic neg_quot_reg;
   logic neg_rem_reg;

   assign a_neg = req_signed & req_a[p_nbits-1];
   assign b_neg = req_signed & req_b[p_nbits-1];
   // Magnitudes wrap: |most-negative| stays most-negative, read as unsigned.
   assign a_mag = a_neg ? -req_a : req_a;
   assign b_mag = b_neg ? -req_b : req_b;
   // A zero divisor keeps the all-ones quotient of the unsigned loop.
   assign quot_fix = (neg_quot_reg && (div_reg != '0)) ? -quot_step : quot_step;
   assign rem_fix  = neg_rem_reg ? -rem_step : rem_step;
`else
   logic unused_req_signed;

   assign unused_req_signed = req_signed;
   assign a_mag    = req_a;
   assign b_mag    = req_b;
   assign quot_fix = quot_step;
   assign rem_fix  = rem_step;
`endif

   int_div_step #(
      .p_nbits (p_nbits)
   ) u_step (
      .rem       (rem_reg),
      .quot      (quot_reg),
      .divisor   (div_reg),
      .rem_next  (rem_step),
      .quot_next (quot_step)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      state_next = state;
      req_rdy    = 1'b0;
      resp_val   = 1'b0;
      unique case (state)
         IDLE: begin
            req_rdy = ~reset;
            if (req_val && !reset) begin
               state_next = CALC;
            end
         end
         CALC: begin
            if (calc_last) begin
               state_next = DONE;
            end
         end
         DONE: begin
            resp_val = 1'b1;
            // req_rdy stays low here, so a request waits one more cycle.
            if (resp_rdy) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // NOTE: the whole datapath is reset, not just the visible outputs, so an
   // aborted operation leaves no stale operands behind.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rem_reg      <= '0;
         quot_reg     <= '0;
         div_reg      <= '0;
         cnt_reg      <= '0;
         resp_quot    <= '0;
         resp_rem     <= '0;
`ifdef INT_DIV_SIGNED_EN
         neg_quot_reg <= 1'b0;
         neg_rem_reg  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (req_go) begin
                  rem_reg      <= '0;
                  quot_reg     <= a_mag;
                  div_reg      <= b_mag;
                  cnt_reg      <= c_cnt_last;
`ifdef INT_DIV_SIGNED_EN
                  neg_quot_reg <= a_neg ^ b_neg;
                  neg_rem_reg  <= a_neg;
`endif
               end
            end
            CALC: begin
               rem_reg  <= rem_step;
               quot_reg <= quot_step;
               if (calc_last) begin
                  resp_quot <= quot_fix;
                  resp_rem  <= rem_fix;
               end else begin
                  cnt_reg <= cnt_reg - c_cnt_w'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule

// File: tb/tb_int_div_iterative.sv
// -----------------------------------------------------------------------------
// tb_int_div_iterative
// Self-checking bench for int_div_iterative at p_nbits = 32 and p_nbits = 8.
// Expected results come from constants or a behavioural reference built on
// the simulator's own / and % operators; a scoreboard queue holds them until
// the matching response handshake.
// -----------------------------------------------------------------------------
module tb_int_div_iterative;

   logic clk;
   logic reset;

   // 32-bit instance
   logic        v32, r32, s32, rv32, rr32;
   logic [31:0] a32, b32, q32, m32;
   // 8-bit instance
   logic        v8, r8, s8, rv8, rr8;
   logic [7:0]  a8, b8, q8, m8;

   int pass_cnt  = 0;
   int total_cnt = 0;

   logic [31:0] sa_q[$];
   logic [31:0] sb_q[$];
   bit          ss_q[$];
   logic [63:0] ex_q[$];   // optional literal expectations for directed runs
   logic [63:0] exp_q[$];  // scoreboard

   int_div_iterative #(.p_nbits(32)) u_dut32 (
      .clk (clk), .reset (reset),
      .req_val (v32), .req_rdy (r32), .req_a (a32), .req_b (b32),
      .req_signed (s32), .resp_val (rv32), .resp_rdy (rr32),
      .resp_quot (q32), .resp_rem (m32)
   );

   int_div_iterative #(.p_nbits(8)) u_dut8 (
      .clk (clk), .reset (reset),
      .req_val (v8), .req_rdy (r8), .req_a (a8), .req_b (b8),
      .req_signed (s8), .resp_val (rv8), .resp_rdy (rr8),
      .resp_quot (q8), .resp_rem (m8)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: {quot, rem}, each zero-extended to 32 bits.
   function automatic logic [63:0] model(input int nb, input logic [31:0] a_in,
                                         input logic [31:0] b_in, input bit sgn);
      logic [31:0] mask;
      logic [31:0] a;
      logic [31:0] b;
      longint      sa, sb, q, r;
      mask = (nb == 32) ? 32'hFFFF_FFFF : ((32'd1 << nb) - 32'd1);
      a = a_in & mask;
      b = b_in & mask;
      if (b == 32'd0) return {mask, a};
`ifdef INT_DIV_SIGNED_EN
      if (sgn) begin
         sa = longint'(a);
         sb = longint'(b);
         if (a[nb-1]) sa = sa - (longint'(1) << nb);
         if (b[nb-1]) sb = sb - (longint'(1) << nb);
         q = sa / sb;
         r = sa % sb;
         return {32'(q) & mask, 32'(r) & mask};
      end
`else
      if (sgn) begin
         // signed requests are plain unsigned divisions in this build
      end
`endif
      return {a / b, a % b};
   endfunction

   function automatic logic cur_rdy(input bit sel8);
      return sel8 ? r8 : r32;
   endfunction

   function automatic logic cur_rv(input bit sel8);
      return sel8 ? rv8 : rv32;
   endfunction

   function automatic logic [63:0] cur_res(input bit sel8);
      return sel8 ? {24'd0, q8, 24'd0, m8} : {q32, m32};
   endfunction

   task automatic drive(input bit sel8, input logic val, input logic [31:0] a,
                        input logic [31:0] b, input logic sgn, input logic rr);
      if (sel8) begin
         v8 = val; a8 = a[7:0]; b8 = b[7:0]; s8 = sgn; rr8 = rr;
      end else begin
         v32 = val; a32 = a; b32 = b; s32 = sgn; rr32 = rr;
      end
   endtask

   task automatic push_stim(input logic [31:0] a, input logic [31:0] b, input bit s);
      sa_q.push_back(a);
      sb_q.push_back(b);
      ss_q.push_back(s);
   endtask

   // Streams the queued requests through one instance. mode 0: random
   // resp_rdy backpressure; mode 1: resp_rdy held high, checks N+2 spacing.
   task automatic run_stream(input bit sel8, input int mode, input string tag);
      int          n, nb, idx, got, cyc, acc_cyc, prev_acc, budget;
      bit          seen, fire, take;
      logic        rr;
      logic [63:0] e, act;
      n = sa_q.size(); nb = sel8 ? 8 : 32;
      idx = 0; got = 0; cyc = 0; acc_cyc = 0; prev_acc = -1; seen = 1'b1;
      budget = n * (nb + 12) + 50;
      while (got < n && cyc < budget) begin
         rr = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
         if (idx < n) drive(sel8, 1'b1, sa_q[idx], sb_q[idx], ss_q[idx], rr);
         else         drive(sel8, 1'b0, 32'd0, 32'd0, 1'b0, rr);
         fire = (idx < n) && cur_rdy(sel8);
         take = cur_rv(sel8) && rr;
         if (fire) begin
            if (ex_q.size() == n) exp_q.push_back(ex_q[idx]);
            else                  exp_q.push_back(model(nb, sa_q[idx], sb_q[idx], ss_q[idx]));
         end
         if (cur_rv(sel8) && !seen) begin
            seen = 1'b1;
            total_cnt++;
            if ((cyc - acc_cyc) !== nb)
               $display("FAIL %s latency: got %0d edges, want %0d", tag, cyc - acc_cyc, nb);
            else pass_cnt++;
         end
         if (take) begin
            e = (exp_q.size() != 0) ? exp_q.pop_front() : 64'hx;
            act = cur_res(sel8);
            total_cnt++;
            if (act !== e)
               $display("FAIL %s result #%0d: got quot=%h rem=%h, want quot=%h rem=%h",
                        tag, got, act[63:32], act[31:0], e[63:32], e[31:0]);
            else pass_cnt++;
            got++;
         end
         @(posedge clk); #1;
         cyc++;
         if (fire) begin
            if (mode == 1 && prev_acc >= 0) begin
               total_cnt++;
               if ((cyc - prev_acc) !== nb + 2)
                  $display("FAIL %s spacing: got %0d cycles, want %0d", tag, cyc - prev_acc, nb + 2);
               else pass_cnt++;
            end
            prev_acc = cyc; acc_cyc = cyc; seen = 1'b0; idx++;
         end
      end
      drive(sel8, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      if (got < n) begin
         total_cnt++;
         $display("FAIL %s timeout: got %0d responses, want %0d", tag, got, n);
      end
      sa_q.delete(); sb_q.delete(); ss_q.delete(); ex_q.delete(); exp_q.delete();
   endtask

   task automatic start32(input logic [31:0] a, input logic [31:0] b, input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (r32) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total_cnt++;
      if (!ok) $display("FAIL %s req_rdy: got 0, want 1", tag);
      else pass_cnt++;
      v32 = 1'b1; a32 = a; b32 = b; s32 = 1'b0;
      @(posedge clk); #1;
      v32 = 1'b0;
   endtask

   task automatic wait_rv32(input string tag);
      bit ok = 1'b0;
      for (int i = 0; i < 100 && !ok; i++) begin
         if (rv32) ok = 1'b1;
         else begin @(posedge clk); #1; end
      end
      total_cnt++;
      if (!ok) $display("FAIL %s resp_val timeout: got 0, want 1", tag);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      #1;
      total_cnt++;
      if ({rv32, r32, q32, m32, rv8, r8} !== 68'd0)
         $display("FAIL reset_state: got rv=%b rdy=%b q=%h r=%h, want all zero", rv32, r32, q32, m32);
      else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({r32, r8, rv32, rv8} !== 4'b1100)
         $display("FAIL reset_release: got rdy32=%b rdy8=%b rv32=%b rv8=%b, want 1 1 0 0", r32, r8, rv32, rv8);
      else pass_cnt++;
   endtask

   task automatic test_unsigned();
      push_stim(32'd100, 32'd7, 1'b0);          ex_q.push_back({32'd14, 32'd2});
      push_stim(32'd5, 32'd7, 1'b0);            ex_q.push_back({32'd0, 32'd5});
      push_stim(32'hFFFF_FFFF, 32'd1, 1'b0);    ex_q.push_back({32'hFFFF_FFFF, 32'd0});
      push_stim(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0); ex_q.push_back({32'd1, 32'd0});
      push_stim(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b0); ex_q.push_back({32'd0, 32'hFFFF_FFFE});
      run_stream(1'b0, 0, "unsigned32");
      push_stim(32'd200, 32'd9, 1'b0);          ex_q.push_back({32'd22, 32'd2});
      push_stim(32'd255, 32'd255, 1'b0);        ex_q.push_back({32'd1, 32'd0});
      run_stream(1'b1, 0, "unsigned8");
   endtask

   task automatic test_div_zero();
      push_stim(32'h1234, 32'd0, 1'b0);         ex_q.push_back({32'hFFFF_FFFF, 32'h1234});
      push_stim(32'hFFFF_FFFB, 32'd0, 1'b1);    ex_q.push_back({32'hFFFF_FFFF, 32'hFFFF_FFFB});
      run_stream(1'b0, 0, "divzero32");
      push_stim(32'h81, 32'd0, 1'b0);           ex_q.push_back({32'hFF, 32'h81});
      run_stream(1'b1, 0, "divzero8");
   endtask

`ifdef INT_DIV_SIGNED_EN
   task automatic test_signed();
      push_stim(32'hFFFF_FFF9, 32'd2, 1'b1);    ex_q.push_back({32'hFFFF_FFFD, 32'hFFFF_FFFF});
      push_stim(32'd7, 32'hFFFF_FFFE, 1'b1);    ex_q.push_back({32'hFFFF_FFFD, 32'd1});
      push_stim(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); ex_q.push_back({32'h8000_0000, 32'd0});
      push_stim(32'hFFFF_FFF9, 32'hFFFF_FFFE, 1'b1); ex_q.push_back({32'd3, 32'hFFFF_FFFF});
      run_stream(1'b0, 0, "signed32");
      push_stim(32'h80, 32'hFF, 1'b1);          ex_q.push_back({32'h80, 32'd0});
      run_stream(1'b1, 0, "signed8");
   endtask
`else
   task automatic test_signed();
      // req_signed is ignored: these are unsigned divisions.
      push_stim(32'hFFFF_FFF9, 32'd2, 1'b1);    ex_q.push_back({32'h7FFF_FFFC, 32'd1});
      push_stim(32'd7, 32'hFFFF_FFFE, 1'b1);    ex_q.push_back({32'd0, 32'd7});
      push_stim(32'h8000_0000, 32'hFFFF_FFFF, 1'b1); ex_q.push_back({32'd0, 32'h8000_0000});
      run_stream(1'b0, 0, "signed_ignored32");
      push_stim(32'h80, 32'hFF, 1'b1);          ex_q.push_back({32'd0, 32'h80});
      run_stream(1'b1, 0, "signed_ignored8");
   endtask
`endif

   task automatic test_backpressure();
      rr32 = 1'b0;
      start32(32'd100, 32'd7, "bp");
      wait_rv32("bp");
      // A request is pending throughout DONE; it must wait for IDLE.
      v32 = 1'b1; a32 = 32'd9; b32 = 32'd3; s32 = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         total_cnt++;
         if ({rv32, r32, q32, m32} !== {1'b1, 1'b0, 32'd14, 32'd2})
            $display("FAIL bp_hold cycle %0d: got rv=%b rdy=%b q=%h r=%h, want rv=1 rdy=0 q=0000000e r=00000002",
                     i, rv32, r32, q32, m32);
         else pass_cnt++;
      end
      rr32 = 1'b1;
      @(posedge clk); #1;
      rr32 = 1'b0;
      total_cnt++;
      if ({rv32, r32} !== 2'b01)
         $display("FAIL bp_release: got rv=%b rdy=%b, want rv=0 rdy=1", rv32, r32);
      else pass_cnt++;
      @(posedge clk); #1;
      v32 = 1'b0;
      total_cnt++;
      if (r32 !== 1'b0) $display("FAIL bp_next_accept: got rdy=%b, want 0", r32);
      else pass_cnt++;
      wait_rv32("bp_next");
      total_cnt++;
      if ({q32, m32} !== {32'd3, 32'd0})
         $display("FAIL bp_next_result: got q=%h r=%h, want q=00000003 r=00000000", q32, m32);
      else pass_cnt++;
      rr32 = 1'b1;
      @(posedge clk); #1;
      rr32 = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) push_stim($urandom, $urandom_range(1, 1000), 1'($urandom_range(0, 1)));
      run_stream(1'b0, 1, "b2b32");
      for (int i = 0; i < 4; i++) push_stim($urandom, $urandom, 1'($urandom_range(0, 1)));
      run_stream(1'b1, 1, "b2b8");
   endtask

   task automatic test_reset_mid();
      start32(32'd1000, 32'd3, "rst_calc");
      repeat (4) @(posedge clk);
      #1;
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({rv32, r32} !== 2'b00)
         $display("FAIL rst_calc_immediate: got rv=%b rdy=%b, want 0 0", rv32, r32);
      else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      #1;
      total_cnt++;
      if ({r32, rv32, q32, m32} !== {1'b1, 1'b0, 64'd0})
         $display("FAIL rst_calc_release: got rdy=%b rv=%b q=%h r=%h, want 1 0 0 0", r32, rv32, q32, m32);
      else pass_cnt++;
      push_stim(32'd9, 32'd3, 1'b0); ex_q.push_back({32'd3, 32'd0});
      run_stream(1'b0, 0, "rst_calc_fresh");
      // Reset while a result is waiting in DONE.
      rr32 = 1'b0;
      start32(32'd77, 32'd5, "rst_done");
      wait_rv32("rst_done");
      reset = 1'b1;
      #1;
      total_cnt++;
      if ({rv32, q32, m32} !== 65'd0)
         $display("FAIL rst_done_clear: got rv=%b q=%h r=%h, want 0 0 0", rv32, q32, m32);
      else pass_cnt++;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_random();
      logic [31:0] a, b;
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: b = 32'hFFFF_FFFF;
            2: a = 32'h8000_0000;
            3: b = $urandom_range(1, 15);
            default: ;
         endcase
         push_stim(a, b, 1'($urandom_range(0, 1)));
      end
      run_stream(1'b0, 0, "random32");
      for (int i = 0; i < 500; i++) begin
         a = $urandom;
         b = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: b = 32'hFF;
            2: a = 32'h80;
            default: ;
         endcase
         push_stim(a, b, 1'($urandom_range(0, 1)));
      end
      run_stream(1'b1, 0, "random8");
   endtask

   initial begin
      reset = 1'b1;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
      test_reset();
      test_unsigned();
      test_div_zero();
      test_signed();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
